// File: rtl/bit_serial_alu_ctrl_if.sv
// Operand/result handshake and 1-bit slice connections for bit_serial_alu_ctrl.
// slave = sequencer side; master = operand source and slice side.
interface bit_serial_alu_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic [2:0]   op_sel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         s_a;
  logic         s_b;
  logic         s_a_invert;
  logic         s_b_invert;
  logic         s_carry_in;
  logic [1:0]   s_op;
  logic         s_less;
  logic         s_result;
  logic         s_carry;

  modport slave (
    input  start, op_sel, a, b, s_result, s_carry,
    output ready, done, result, carry_out, overflow, zero,
           s_a, s_b, s_a_invert, s_b_invert, s_carry_in, s_op, s_less
  );

  modport master (
    output start, op_sel, a, b, s_result, s_carry,
    input  ready, done, result, carry_out, overflow, zero,
           s_a, s_b, s_a_invert, s_b_invert, s_carry_in, s_op, s_less
  );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// Sequencer driving one external 1-bit ALU slice LSB first to run W-bit
// AND/OR/ADD/SUB/NOR/SLT, reporting result, carry, overflow and zero flags.
module bit_serial_alu_ctrl #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  bit_serial_alu_ctrl_if.slave  bus
);
  localparam int KW = $clog2(W);
  localparam logic [KW-1:0] K_LAST = KW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SLT2, S_DONE} state_e;
  typedef enum logic [2:0] {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLT} op_e;

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [KW-1:0] k_q, k_d;
  logic         carry_q, carry_d, set_q, set_d;
  logic         cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic         cin;
  logic         finish;

  function automatic op_e decode(input logic [2:0] sel);
    case (sel)
      3'b001:  return OP_OR;
      3'b010:  return OP_ADD;
      3'b011:  return OP_SUB;
      3'b100:  return OP_NOR;
      3'b101:  return OP_SLT;
      default: return OP_AND;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      set_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      set_q   <= set_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    res_d          = res_q;
    k_d            = k_q;
    carry_d        = carry_q;
    set_d          = set_q;
    cout_d         = cout_q;
    ovf_d          = ovf_q;
    zero_d         = zero_q;
    finish         = 1'b0;
    cin            = 1'b0;
    bus.s_a        = 1'b0;
    bus.s_b        = 1'b0;
    bus.s_a_invert = 1'b0;
    bus.s_b_invert = 1'b0;
    bus.s_carry_in = 1'b0;
    bus.s_op       = 2'b00;
    bus.s_less     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = decode(bus.op_sel);
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        bus.s_a = a_q[k_q];
        bus.s_b = b_q[k_q];
        case (op_q)
          OP_OR:  bus.s_op = 2'b01;
          OP_NOR: begin
            bus.s_a_invert = 1'b1;
            bus.s_b_invert = 1'b1;
          end
          OP_ADD: bus.s_op = 2'b10;
          OP_SUB, OP_SLT: begin
            bus.s_op       = 2'b10;
            bus.s_b_invert = 1'b1;
          end
          default: bus.s_op = 2'b00;
        endcase
        cin            = (k_q == '0) ? (op_q == OP_SUB || op_q == OP_SLT) : carry_q;
        bus.s_carry_in = cin;
        res_d[k_q]     = bus.s_result;
        carry_d        = bus.s_carry;
        k_d            = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d = '0;
          // SLT's set bit is sign-of-difference corrected by the signed overflow.
          set_d = bus.s_result ^ (cin ^ bus.s_carry);
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            cout_d = bus.s_carry;
            ovf_d  = cin ^ bus.s_carry;
          end else begin
            cout_d = 1'b0;
            ovf_d  = 1'b0;
          end
          if (op_q == OP_SLT) begin
            state_d = S_SLT2;
          end else begin
            state_d = S_DONE;
            finish  = 1'b1;
          end
        end
      end
      S_SLT2: begin
        bus.s_a    = a_q[k_q];
        bus.s_b    = b_q[k_q];
        bus.s_op   = 2'b11;
        bus.s_less = (k_q == '0) ? set_q : 1'b0;
        res_d[k_q] = bus.s_result;
        k_d        = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_DONE;
          finish  = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      zero_d = (res_d == '0);
    end
  end

  // Flags are only published on entry to DONE, so they hold across later runs until then.
  logic cout_pub_q, ovf_pub_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cout_pub_q <= 1'b0;
      ovf_pub_q  <= 1'b0;
    end else if (finish) begin
      cout_pub_q <= cout_d;
      ovf_pub_q  <= ovf_d;
    end
  end

  assign bus.ready     = (state_q == S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = res_q;
  assign bus.carry_out = cout_pub_q;
  assign bus.overflow  = ovf_pub_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Random and directed checks of bit_serial_alu_ctrl against an arithmetic
// reference model, with a behavioural 1-bit ALU slice attached.
module tb_bit_serial_alu_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bit_serial_alu_ctrl_if #(.W(W)) bus ();
  bit_serial_alu_ctrl #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Behavioural 1-bit slice: combinational from the sequencer's s_* outputs.
  logic sl_a, sl_b;
  always_comb begin
    sl_a        = bus.s_a ^ bus.s_a_invert;
    sl_b        = bus.s_b ^ bus.s_b_invert;
    bus.s_carry = (sl_a & sl_b) | (sl_a & bus.s_carry_in) | (sl_b & bus.s_carry_in);
    case (bus.s_op)
      2'b00:   bus.s_result = sl_a & sl_b;
      2'b01:   bus.s_result = sl_a | sl_b;
      2'b10:   bus.s_result = sl_a ^ sl_b ^ bus.s_carry_in;
      default: bus.s_result = bus.s_less;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0] wide;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b001: r = a | b;
      3'b010: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[W-1:0];
        c = wide[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b011: begin
        wide = {1'b0, a} + {1'b0, ~b} + 1;
        r = wide[W-1:0];
        c = wide[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b100: r = ~(a | b);
      3'b101: r = ($signed(a) < $signed(b)) ? W'(1) : '0;
      default: r = a & b;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold);
    logic [W-1:0] er;
    logic ec, ev;
    int n;
    bit busy_ok;
    ref_model(op, a, b, er, ec, ev);
    @(negedge clk);
    check("ready_idle", bus.ready, 1);
    bus.start  = 1'b1;
    bus.op_sel = op;
    bus.a      = a;
    bus.b      = b;
    @(posedge clk);
    n = 0;
    busy_ok = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (!hold) bus.start = 1'b0;
      bus.a      = W'($urandom);
      bus.b      = W'($urandom);
      bus.op_sel = 3'($urandom);
      if (bus.done) break;
      if (bus.ready) busy_ok = 1'b0;
    end
    check("done_seen", bus.done, 1);
    check("latency", n, (op == 3'b101) ? 2 * W + 1 : W + 1);
    check("result", bus.result, er);
    check("carry_out", bus.carry_out, ec);
    check("overflow", bus.overflow, ev);
    check("zero", bus.zero, (er == '0));
    check("busy_not_ready", busy_ok, 1);
    @(negedge clk);
    bus.start = 1'b0;
    check("done_one_cycle", bus.done, 0);
    check("ready_after", bus.ready, 1);
    check("result_held", bus.result, er);
    if (hold) begin
      @(negedge clk);
      check("no_queued_op", bus.ready, 1);
    end
  endtask

  initial begin
    bit done_seen;
    bus.start  = 1'b0;
    bus.op_sel = '0;
    bus.a      = '0;
    bus.b      = '0;
    reset      = 1'b1;
    #1;
    check("rst_ready", bus.ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_flags", {bus.carry_out, bus.overflow, bus.zero}, 3'b001);
    check("rst_slice", {bus.s_a, bus.s_b, bus.s_a_invert, bus.s_b_invert, bus.s_carry_in,
                        bus.s_op, bus.s_less}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(3'b010, 8'h7F, 8'h01, 1'b0);
    run_op(3'b011, 8'h05, 8'h05, 1'b0);
    run_op(3'b011, 8'h80, 8'h01, 1'b0);
    run_op(3'b101, 8'h80, 8'h01, 1'b0);
    run_op(3'b101, 8'h01, 8'h80, 1'b0);
    run_op(3'b101, 8'h7F, 8'h80, 1'b0);
    run_op(3'b000, 8'hF0, 8'h3C, 1'b0);
    run_op(3'b001, 8'hF0, 8'h3C, 1'b0);
    run_op(3'b100, 8'hF0, 8'h0C, 1'b0);
    run_op(3'b110, 8'hF0, 8'h3C, 1'b0);
    run_op(3'b111, 8'hF0, 8'h3C, 1'b0);
    run_op(3'b010, 8'hFF, 8'h01, 1'b0);
    run_op(3'b010, 8'h23, 8'h45, 1'b1);

    // Reset mid-operation at bit k=3.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_sel = 3'b010;
    bus.a      = 8'h12;
    bus.b      = 8'h34;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("mid_rst_ready", bus.ready, 1);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_zero", bus.zero, 1);
    check("mid_rst_slice", {bus.s_a, bus.s_b, bus.s_a_invert, bus.s_b_invert, bus.s_carry_in,
                            bus.s_op, bus.s_less}, 0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    check("no_done_after_rst", done_seen, 0);
    check("idle_after_rst", bus.ready, 1);
    run_op(3'b010, 8'h12, 8'h34, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
